// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NUM_RD combinational read ports,
// post-reset clear engine and per-register busy scoreboard. Optional write-to-read
// bypass is compiled in with `define REGFILE_WR_BYPASS_EN.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_RD*AW-1:0]   i_rs_addr,
  output logic [NUM_RD*XLEN-1:0] o_rs_data,
  output logic [NUM_RD-1:0]      o_rs_busy,
  input  logic                   i_wr0_wren,
  input  logic [AW-1:0]          i_wr0_addr,
  input  logic [XLEN-1:0]        i_wr0_data,
  input  logic                   i_wr1_wren,
  input  logic [AW-1:0]          i_wr1_addr,
  input  logic [XLEN-1:0]        i_wr1_data,
  input  logic                   i_alloc_en,
  input  logic [AW-1:0]          i_alloc_addr,
  output logic                   o_ready
);

  typedef enum logic {CLEAR, READY} state_e;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [XLEN-1:0]   mem_q [DEPTH];
  logic [XLEN-1:0]   mem_d [DEPTH];
  logic              is_ready;
  logic              wr0_ok, wr1_ok, alloc_ok;

  // Qualified requests: only accepted in READY, and address 0 is dropped when hardwired.
  always_comb begin
    is_ready = (state_q == READY);
    wr0_ok   = i_wr0_wren && is_ready && !((ZERO_REG != 0) && (i_wr0_addr == '0));
    wr1_ok   = i_wr1_wren && is_ready && !((ZERO_REG != 0) && (i_wr1_addr == '0));
    alloc_ok = i_alloc_en && is_ready && !((ZERO_REG != 0) && (i_alloc_addr == '0));
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy_d    = busy_q;
    mem_d     = mem_q;
    if (state_q == CLEAR) begin
      mem_d[clr_cnt_q] = '0;
      clr_cnt_d        = clr_cnt_q + AW'(1);
      if (clr_cnt_q == LAST) state_d = READY;
    end else begin
      if (wr0_ok) begin
        mem_d[i_wr0_addr]  = i_wr0_data;
        busy_d[i_wr0_addr] = 1'b0;
      end
      // Port 1 applied after port 0 so it wins on a shared address.
      if (wr1_ok) begin
        mem_d[i_wr1_addr]  = i_wr1_data;
        busy_d[i_wr1_addr] = 1'b0;
      end
      if (alloc_ok) busy_d[i_alloc_addr] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= busy_d;
      mem_q     <= mem_d;
    end
  end

  always_comb begin
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    logic            rb;
    o_rs_data = '0;
    o_rs_busy = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      ra = i_rs_addr[k*AW +: AW];
      rd = mem_q[ra];
      rb = busy_q[ra];
`ifdef REGFILE_WR_BYPASS_EN
      if (wr0_ok && (i_wr0_addr == ra)) begin
        rd = i_wr0_data;
        rb = alloc_ok && (i_alloc_addr == ra);
      end
      if (wr1_ok && (i_wr1_addr == ra)) begin
        rd = i_wr1_data;
        rb = alloc_ok && (i_alloc_addr == ra);
      end
`endif
      if (!is_ready || ((ZERO_REG != 0) && (ra == '0))) begin
        rd = '0;
        rb = 1'b0;
      end
      o_rs_data[k*XLEN +: XLEN] = rd;
      o_rs_busy[k]              = rb;
    end
  end

  assign o_ready = is_ready;

endmodule
